// File: rtl/jt7759_feeder.sv
// Slave-mode host for the JT7759: fetches a sound's header and command stream from ROM
// and feeds it byte by byte into the chip's CPU port whenever the chip raises a request.
module jt7759_feeder #(
    parameter int unsigned WRW  = 2,
    parameter int unsigned TOUT = 4095
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        start,
    input  logic [7:0]  snd,
    input  logic        stop,
    output logic        busy,
    output logic        done,
    output logic        tout_err,
    output logic        rom_cs,
    output logic [16:0] rom_addr,
    input  logic [7:0]  rom_data,
    input  logic        rom_ok,
    output logic        chip_cs,
    output logic        chip_wrn,
    output logic [7:0]  chip_din,
    input  logic        chip_drqn
);
    localparam int unsigned TW = 4;
    localparam int unsigned CW = 12;
    localparam int unsigned RW = 9;

    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] HDRH   = 4'd1;
    localparam logic [3:0] HDRL   = 4'd2;
    localparam logic [3:0] SNDNUM = 4'd3;
    localparam logic [3:0] WREQ   = 4'd4;
    localparam logic [3:0] FETCH  = 4'd5;
    localparam logic [3:0] WRITE  = 4'd6;
    localparam logic [3:0] WREL   = 4'd7;
    localparam logic [3:0] DONE   = 4'd8;

    logic [3:0]    state, state_d;
    logic [7:0]    snd_q, snd_d, ahi, ahi_d, alo, alo_d;
    logic [2:0]    pre, pre_d;
    logic [RW-1:0] rem, rem_d;
    logic          len_next, len_d, hdr_seen, hdr_d, end_flag, end_d, stop_pend, stop_d;
    logic [TW-1:0] tick, tick_d;
    logic [CW-1:0] tcnt, tcnt_d;
    logic          busy_d, done_d, tout_d, rom_cs_d, chip_cs_d, wrn_d;
    logic [16:0]   rom_addr_d;
    logic [7:0]    din_d, pre_byte_c;

    // Fixed preamble after the sound number: dummy, address high, address low, dummy
    always_comb begin
        pre_byte_c = 8'h00;
        case (pre)
            3'd1:    pre_byte_c = ahi;
            3'd2:    pre_byte_c = alo;
            default: pre_byte_c = 8'h00;
        endcase
    end

    always_comb begin
        state_d    = state;
        snd_d      = snd_q;
        ahi_d      = ahi;
        alo_d      = alo;
        pre_d      = pre;
        rem_d      = rem;
        len_d      = len_next;
        hdr_d      = hdr_seen;
        end_d      = end_flag;
        stop_d     = stop_pend;
        tick_d     = tick;
        tcnt_d     = tcnt;
        busy_d     = busy;
        done_d     = 1'b0;
        tout_d     = tout_err;
        rom_cs_d   = rom_cs;
        rom_addr_d = rom_addr;
        chip_cs_d  = chip_cs;
        wrn_d      = chip_wrn;
        din_d      = chip_din;
        case (state)
            IDLE: if (start) begin
                snd_d      = snd;
                tout_d     = 1'b0;
                busy_d     = 1'b1;
                rom_cs_d   = 1'b1;
                rom_addr_d = {8'd0, snd, 1'b0} + 17'd5;
                pre_d      = 3'd0;
                rem_d      = '0;
                len_d      = 1'b0;
                hdr_d      = 1'b0;
                end_d      = 1'b0;
                stop_d     = 1'b0;
                state_d    = HDRH;
            end
            HDRH, HDRL, SNDNUM, FETCH: begin
                if (stop) begin
                    rom_cs_d = 1'b0;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else if (state == SNDNUM) begin
                    din_d     = snd_q;
                    chip_cs_d = 1'b1;
                    wrn_d     = 1'b0;
                    tick_d    = '0;
                    state_d   = WRITE;
                end else if (rom_ok && state == HDRH) begin
                    ahi_d      = rom_data;
                    rom_addr_d = rom_addr + 17'd1;
                    state_d    = HDRL;
                end else if (rom_ok && state == HDRL) begin
                    alo_d      = rom_data;
                    rom_cs_d   = 1'b0;
                    rom_addr_d = {ahi, rom_data, 1'b0} + 17'd1;
                    state_d    = SNDNUM;
                end else if (rom_ok) begin
                    rom_cs_d   = 1'b0;
                    rom_addr_d = rom_addr + 17'd1;
                    din_d      = rom_data;
                    chip_cs_d  = 1'b1;
                    wrn_d      = 1'b0;
                    tick_d     = '0;
                    state_d    = WRITE;
                    // Command parser: length byte, pass-through data, or command
                    if (len_next) begin
                        len_d = 1'b0;
                        rem_d = RW'(rom_data[7:1]) + 9'd1;
                    end else if (rem != '0) begin
                        rem_d = rem - 9'd1;
                    end else if (rom_data == 8'h00) begin
                        end_d = hdr_seen;
                    end else begin
                        hdr_d = 1'b1;
                        if (rom_data[7:6] == 2'b01)      rem_d = 9'd128;
                        else if (rom_data[7:6] == 2'b10) len_d = 1'b1;
                    end
                end
            end
            WREQ: begin
                if (stop) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (!chip_drqn) begin
                    if (pre != 3'd4) begin
                        din_d     = pre_byte_c;
                        pre_d     = pre + 3'd1;
                        chip_cs_d = 1'b1;
                        wrn_d     = 1'b0;
                        tick_d    = '0;
                        state_d   = WRITE;
                    end else begin
                        rom_cs_d = 1'b1;
                        state_d  = FETCH;
                    end
                end else if (cen) begin
                    if (tcnt == CW'(TOUT - 1)) begin
                        tout_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        tcnt_d = tcnt + 12'd1;
                    end
                end
            end
            WRITE: begin
                // stop is deferred so the write pulse always has its full width
                if (stop) stop_d = 1'b1;
                if (cen) begin
                    if (tick == TW'(WRW - 1)) begin
                        wrn_d   = 1'b1;
                        state_d = WREL;
                    end else begin
                        tick_d = tick + 4'd1;
                    end
                end
            end
            WREL: begin
                chip_cs_d = 1'b0;
                if (stop_pend || stop) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (end_flag) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else if (chip_drqn) begin
                    tcnt_d  = '0;
                    state_d = WREQ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            snd_q     <= '0;
            ahi       <= '0;
            alo       <= '0;
            pre       <= '0;
            rem       <= '0;
            len_next  <= 1'b0;
            hdr_seen  <= 1'b0;
            end_flag  <= 1'b0;
            stop_pend <= 1'b0;
            tick      <= '0;
            tcnt      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tout_err  <= 1'b0;
            rom_cs    <= 1'b0;
            rom_addr  <= '0;
            chip_cs   <= 1'b0;
            chip_wrn  <= 1'b1;
            chip_din  <= '0;
        end else begin
            state     <= state_d;
            snd_q     <= snd_d;
            ahi       <= ahi_d;
            alo       <= alo_d;
            pre       <= pre_d;
            rem       <= rem_d;
            len_next  <= len_d;
            hdr_seen  <= hdr_d;
            end_flag  <= end_d;
            stop_pend <= stop_d;
            tick      <= tick_d;
            tcnt      <= tcnt_d;
            busy      <= busy_d;
            done      <= done_d;
            tout_err  <= tout_d;
            rom_cs    <= rom_cs_d;
            rom_addr  <= rom_addr_d;
            chip_cs   <= chip_cs_d;
            chip_wrn  <= wrn_d;
            chip_din  <= din_d;
        end
    end
endmodule

// File: tb/tb_jt7759_feeder.sv
// Randomized bench for jt7759_feeder: ROM and chip responders plus a stream-level reference model.
module tb_jt7759_feeder;
    localparam int unsigned WRW  = 3;
    localparam int unsigned TOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  snd = 8'h00;
    logic        stop = 1'b0;
    logic        busy, done, tout_err, rom_cs, chip_cs, chip_wrn;
    logic [16:0] rom_addr;
    logic [7:0]  rom_data = 8'h00;
    logic        rom_ok = 1'b0;
    logic [7:0]  chip_din;
    logic        chip_drqn = 1'b1;

    jt7759_feeder #(.WRW(WRW), .TOUT(TOUT)) dut (
        .clk(clk), .rst(rst), .cen(cen), .start(start), .snd(snd), .stop(stop),
        .busy(busy), .done(done), .tout_err(tout_err),
        .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok),
        .chip_cs(chip_cs), .chip_wrn(chip_wrn), .chip_din(chip_din), .chip_drqn(chip_drqn)
    );

    always #5 clk = ~clk;

    logic [7:0]  rom [0:131071];
    logic [7:0]  got_q[$], exp_q[$];
    logic [16:0] gaddr_q[$], eaddr_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int done_cnt = 0;
    bit cen_always = 1'b0;
    bit chip_want = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Responders and monitor; everything sampled and driven on the falling edge
    bit          last_wrn = 1'b1, last_cen = 1'b0, last_busy = 1'b0, last_rcs = 1'b0, served = 1'b0;
    logic [16:0] last_ra = '0;
    logic [7:0]  pdin = '0;
    int          pw = 0, drq_dly = 0, rdly = 0;

    always @(negedge clk) begin
        if (!last_wrn && last_cen) pw++;
        if (last_wrn && !chip_wrn) begin
            pw = 0;
            pdin = chip_din;
            check("cs_with_wrn", 32'(chip_cs), 1);
            chip_drqn = 1'b1;
            drq_dly = $urandom_range(2, 6);
        end
        if (!chip_wrn) check("din_stable", 32'(chip_din), 32'(pdin));
        if (!last_wrn && chip_wrn) begin
            check("wrn_width", pw, WRW);
            check("din_hold", 32'(chip_din), 32'(pdin));
            got_q.push_back(pdin);
        end
        if (done) begin
            done_cnt++;
            check("busy_at_done", 32'(busy), 0);
            check("busy_before_done", 32'(last_busy), 1);
        end
        if (chip_wrn && chip_drqn && chip_want) begin
            if (drq_dly == 0) chip_drqn = 1'b0;
            else drq_dly--;
        end
        if (rom_cs) begin
            if (!last_rcs || rom_addr != last_ra) begin
                rdly = $urandom_range(0, 3);
                served = 1'b0;
            end
            if (!served && rdly == 0) begin
                rom_ok = 1'b1;
                rom_data = rom[rom_addr];
                served = 1'b1;
                gaddr_q.push_back(rom_addr);
            end else begin
                rom_ok = 1'b0;
                if (rdly > 0) rdly--;
            end
        end else begin
            rom_ok = 1'b0;
        end
        last_rcs  = rom_cs;
        last_ra   = rom_addr;
        last_busy = busy;
        last_wrn  = chip_wrn;
        cen       = cen_always ? 1'b1 : ($urandom_range(0, 3) != 0);
        last_cen  = cen;
    end

    function automatic logic [7:0] take(inout int p);
        logic [7:0] b;
        b = rom[p];
        exp_q.push_back(b);
        eaddr_q.push_back(17'(p));
        p = (p + 1) % 131072;
        return b;
    endfunction

    // Expected chip byte list and ROM address list for sound s, straight from the stream rules
    function automatic void build_expect(input logic [7:0] s);
        int si, a, p, n;
        logic [7:0] b;
        bit hdr;
        si = int'(s);
        exp_q.delete();
        eaddr_q.delete();
        a = int'(rom[2*si+5]) * 256 + int'(rom[2*si+6]);
        exp_q.push_back(s);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'(a / 256));
        exp_q.push_back(8'(a % 256));
        exp_q.push_back(8'h00);
        eaddr_q.push_back(17'(2*si+5));
        eaddr_q.push_back(17'(2*si+6));
        p = (2*a + 1) % 131072;
        hdr = 1'b0;
        for (int g = 0; g < 4096; g++) begin
            b = take(p);
            if (b == 8'h00) begin
                if (hdr) break;
            end else begin
                hdr = 1'b1;
                n = 0;
                if (b >= 8'h40 && b < 8'h80) n = 128;
                else if (b >= 8'h80 && b < 8'hC0) n = int'(take(p)) / 2 + 1;
                for (int k = 0; k < n; k++) void'(take(p));
            end
        end
    endfunction

    task automatic set_hdr(input int s, input int a);
        rom[2*s+5] = 8'(a / 256);
        rom[2*s+6] = 8'(a % 256);
    endtask

    task automatic put(inout int p, input int b);
        rom[p] = 8'(b);
        p = (p + 1) % 131072;
    endtask

    task automatic gen_sound(input int s, input int a);
        int p, n, len;
        set_hdr(s, a);
        p = 2*a + 1;
        repeat ($urandom_range(0, 2)) put(p, 0);
        repeat ($urandom_range(1, 4)) begin
            case ($urandom_range(0, 3))
                0: put(p, $urandom_range(1, 63));
                1: begin
                    put(p, 64 + $urandom_range(0, 63));
                    repeat (128) put(p, $urandom_range(0, 255));
                end
                2: begin
                    put(p, 128 + $urandom_range(0, 63));
                    len = $urandom_range(0, 255);
                    put(p, len);
                    n = len / 2 + 1;
                    repeat (n) put(p, $urandom_range(0, 255));
                end
                default: put(p, 192 + $urandom_range(0, 63));
            endcase
        end
        put(p, 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_tout"}, 32'(tout_err), 0);
        check({tag, "_rom_cs"}, 32'(rom_cs), 0);
        check({tag, "_rom_addr"}, 32'(rom_addr), 0);
        check({tag, "_chip_cs"}, 32'(chip_cs), 0);
        check({tag, "_wrn"}, 32'(chip_wrn), 1);
        check({tag, "_din"}, 32'(chip_din), 0);
    endtask

    task automatic kick(input logic [7:0] s);
        build_expect(s);
        got_q.delete();
        gaddr_q.delete();
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        snd = s;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_sound(input logic [7:0] s, input bit poke);
        int cyc;
        kick(s);
        check("tout_cleared", 32'(tout_err), 0);
        cyc = 0;
        while (busy !== 1'b0 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 40) begin
                start = 1'b1;
                snd = ~s;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("run_ends", 32'(busy), 0);
        repeat (2) @(negedge clk);
        check("done_once", done_cnt, 1);
        check("tout_clear", 32'(tout_err), 0);
        check("nwrites", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        check("nfetch", gaddr_q.size(), eaddr_q.size());
        for (int i = 0; i < eaddr_q.size() && i < gaddr_q.size(); i++)
            check($sformatf("addr%0d", i), 32'(gaddr_q[i]), 32'(eaddr_q[i]));
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 131072; i++) rom[i] = 8'h00;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        // Header 0x0010, stream 0x41 + 128 data + end
        set_hdr(0, 16'h0010);
        begin
            int p;
            p = 16'h21;
            put(p, 8'h41);
            repeat (128) put(p, $urandom_range(0, 255));
            put(p, 0);
        end
        run_sound(8'd0, 1'b0);
        check("first_fetch", 32'(gaddr_q.size() > 2 ? gaddr_q[2] : 17'h0), 17'h21);
        check("rom_writes", got_q.size() - 5, 130);

        // Leading silence, silence, length-coded block of 4 data bytes, end
        set_hdr(1, 16'h0200);
        begin
            int p;
            p = 16'h401;
            put(p, 0); put(p, 5); put(p, 8'h80); put(p, 7);
            repeat (4) put(p, $urandom_range(0, 255));
            put(p, 0);
        end
        run_sound(8'd1, 1'b0);
        check("len_writes", got_q.size() - 5, 9);

        // Random streams; one of them gets a start pulse while busy
        for (int k = 0; k < 5; k++) begin
            gen_sound(100 + k*30, 16'h1000 + k*16'h0800);
            run_sound(8'(100 + k*30), k == 1);
        end

        // ROM address wraps from 0x1FFFF to 0
        set_hdr(255, 16'hFFFF);
        rom[17'h1FFFF] = 8'h05;
        rom[0] = 8'h00;
        run_sound(8'd255, 1'b0);

        // DRQn never asserted after the sound number
        set_hdr(2, 16'h0010);
        chip_want = 1'b0;
        cen_always = 1'b1;
        kick(8'd2);
        cyc = 0;
        while (got_q.size() < 1 && cyc < 500) begin @(negedge clk); cyc++; end
        cyc = 0;
        while (!tout_err && cyc < 100) begin @(negedge clk); cyc++; end
        check("tout_set", 32'(tout_err), 1);
        check("tout_ticks", 32'(cyc >= 15 && cyc <= 19), 1);
        check("tout_busy", 32'(busy), 0);
        repeat (2) @(negedge clk);
        check("tout_nodone", done_cnt, 0);
        check("tout_nwrites", got_q.size(), 1);
        chip_want = 1'b1;
        cen_always = 1'b0;
        run_sound(8'd0, 1'b0);

        // stop during a ROM-phase write pulse
        kick(8'd0);
        cyc = 0;
        while (!(got_q.size() >= 6 && chip_wrn == 1'b0) && cyc < 5000) begin @(negedge clk); cyc++; end
        check("stop_in_pulse", 32'(chip_wrn), 0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        cyc = 0;
        while (busy && cyc < 100) begin @(negedge clk); cyc++; end
        check("stop_busy", 32'(busy), 0);
        repeat (2) @(negedge clk);
        check("stop_nodone", done_cnt, 0);
        check("stop_wrn", 32'(chip_wrn), 1);
        check("stop_cs", 32'(chip_cs), 0);
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("stop_byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        run_sound(8'd0, 1'b0);

        // Synchronous reset during a ROM fetch
        kick(8'd0);
        cyc = 0;
        while (!(got_q.size() >= 7 && rom_cs == 1'b1) && cyc < 5000) begin @(negedge clk); cyc++; end
        check("rst_in_fetch", 32'(rom_cs), 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset("midrst");
        rst = 1'b0;
        run_sound(8'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
